// File: rtl/array_fifo_ctrl.sv
// array_fifo_ctrl: ready/valid FIFO over an external 1R1W sync-read SRAM; ARRAY_FIFO_BYPASS_EN enables empty-FIFO bypass
module array_fifo_ctrl #(
  parameter int DEPTH  = 512,
  parameter int WIDTH  = 74,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [WIDTH-1:0]  enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [WIDTH-1:0]  deq_bits,
  output logic [ADDR_W+1:0] count,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [WIDTH-1:0]  R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [WIDTH-1:0]  W0_data
);
  localparam logic [ADDR_W:0] MEM_FULL = (ADDR_W+1)'(DEPTH);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic              inflight;
  logic [1:0]        oq_cnt;
  logic [WIDTH-1:0]  oq_head, oq_tail;
  logic              enq_fire, deq_fire, rd_fire, bypass, wr_fire, oq_push;
  logic [2:0]        occ;
  logic [1:0]        oq_left;
  logic [WIDTH-1:0]  push_data;
  always_comb begin
    enq_ready = reset_n & (mem_cnt != MEM_FULL);
    enq_fire  = enq_valid & enq_ready;
    deq_valid = oq_cnt != 2'd0;
    deq_fire  = deq_valid & deq_ready;
    occ       = 3'(oq_cnt) + 3'(inflight) - 3'(deq_fire);
    rd_fire   = (mem_cnt != '0) & (occ < 3'd2);
`ifdef ARRAY_FIFO_BYPASS_EN
    bypass    = enq_fire & (mem_cnt == '0) & ~inflight & (occ < 3'd2);
`else
    bypass    = 1'b0;
`endif
    wr_fire   = enq_fire & ~bypass;
    oq_push   = inflight | bypass;
    push_data = inflight ? R0_data : enq_bits;
    oq_left   = oq_cnt - 2'(deq_fire);
  end
  assign W0_en    = wr_fire;
  assign W0_addr  = wr_ptr;
  assign W0_data  = enq_bits;
  assign R0_en    = rd_fire;
  assign R0_addr  = rd_ptr;
  assign deq_bits = oq_head;
  assign count    = (ADDR_W+2)'(mem_cnt) + (ADDR_W+2)'(inflight) + (ADDR_W+2)'(oq_cnt);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      oq_cnt   <= 2'd0;
    end else begin
      wr_ptr   <= wr_ptr + ADDR_W'(wr_fire);
      rd_ptr   <= rd_ptr + ADDR_W'(rd_fire);
      mem_cnt  <= mem_cnt + (ADDR_W+1)'(wr_fire) - (ADDR_W+1)'(rd_fire);
      inflight <= rd_fire;
      oq_cnt   <= oq_cnt + 2'(oq_push) - 2'(deq_fire);
    end
  end
  // a pop shifts tail into head; a push lands in whichever slot is free after the pop
  always_ff @(posedge clock) begin
    if (deq_fire | (oq_push & (oq_cnt == 2'd0)))
      oq_head <= (deq_fire & (oq_cnt == 2'd2)) ? oq_tail : push_data;
    if (oq_push & (oq_left == 2'd1))
      oq_tail <= push_data;
  end
  always_ff @(posedge clock) begin
    if (reset_n) assert (!(oq_push && oq_left == 2'd2));
  end
endmodule

// File: tb/tb_array_fifo_ctrl.sv
// tb_array_fifo_ctrl: directed checks of array_fifo_ctrl against a behavioural SRAM and a scoreboard queue
module tb_array_fifo_ctrl;
  localparam int DEPTH = 512, WIDTH = 74, ADDR_W = 9;
  logic              clock = 1'b0, reset_n = 1'b0, enq_valid = 1'b0, deq_ready = 1'b0;
  logic [WIDTH-1:0]  enq_bits = '0;
  logic              enq_ready, deq_valid, R0_en, W0_en;
  logic [WIDTH-1:0]  deq_bits, R0_data, W0_data, r0_q;
  logic [ADDR_W+1:0] count;
  logic [ADDR_W-1:0] R0_addr, W0_addr;
  logic [WIDTH-1:0]  sram [DEPTH];
  logic [WIDTH-1:0]  q[$];
  logic [WIDTH-1:0]  nxt;
  int total = 0, bad = 0, n_acc, n_deq, n_rd;
`ifdef ARRAY_FIFO_BYPASS_EN
  localparam int FILL_RD = 0, STREAM_DEQ = 1999;
`else
  localparam int FILL_RD = 2, STREAM_DEQ = 1997;
`endif

  array_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .count(count),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (W0_en) sram[W0_addr] <= W0_data;
    if (R0_en) r0_q <= sram[R0_addr];
  end
  assign R0_data = r0_q;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one cycle: drive at posedge+1, check at negedge, score fires, advance to next posedge+1
  task automatic cyc(input logic ev, input logic dr);
    enq_valid = ev;
    enq_bits  = nxt;
    deq_ready = dr;
    #4;
    chk("count_vs_model", 128'(count), 128'(q.size()));
    if (R0_en) n_rd++;
    if (deq_valid && dr) begin
      if (q.size() == 0) chk("deq_underflow", 128'(deq_valid), 128'(0));
      else begin
        chk("deq_order", 128'(deq_bits), 128'(q[0]));
        void'(q.pop_front());
        n_deq++;
      end
    end
    if (ev && enq_ready) begin
      q.push_back(nxt);
      nxt++;
      n_acc++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 700 && q.size() != 0; i++) cyc(1'b0, 1'b1);
    chk({tag, "_drained"}, 128'(q.size()), 128'(0));
    chk({tag, "_count0"}, 128'(count), 128'(0));
  endtask

  initial begin
    nxt = '0;
    enq_valid = 1'b1;
    #2;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_deq_valid", 128'(deq_valid), 128'(0));
    chk("rst_enq_ready", 128'(enq_ready), 128'(0));
    chk("rst_W0_en", 128'(W0_en), 128'(0));
    chk("rst_R0_en", 128'(R0_en), 128'(0));
    enq_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
`ifdef ARRAY_FIFO_BYPASS_EN
    enq_valid = 1'b1; enq_bits = 74'h15; deq_ready = 1'b0;
    #4;
    chk("byp_W0_en_c0", 128'(W0_en), 128'(0));
    chk("byp_enq_ready_c0", 128'(enq_ready), 128'(1));
    @(posedge clock); #1;
    enq_bits = 74'h16;
    #4;
    chk("byp_deq_valid_c1", 128'(deq_valid), 128'(1));
    chk("byp_deq_bits_c1", 128'(deq_bits), 128'h15);
    chk("byp_W0_en_c1", 128'(W0_en), 128'(0));
    @(posedge clock); #1;
    enq_bits = 74'h17;
    #4;
    chk("byp_W0_en_oqfull", 128'(W0_en), 128'(1));
    @(posedge clock); #1;
    enq_bits = 74'h18;
    #4;
    chk("byp_W0_en_memcnt", 128'(W0_en), 128'(1));
    chk("byp_W0_addr", 128'(W0_addr), 128'(1));
    @(posedge clock); #1;
    q = '{74'h15, 74'h16, 74'h17, 74'h18};
    drain("byp");
`else
    enq_valid = 1'b1; enq_bits = 74'h3_DEAD_BEEF; deq_ready = 1'b1;
    #4;
    chk("sw_W0_en", 128'(W0_en), 128'(1));
    chk("sw_W0_addr", 128'(W0_addr), 128'(0));
    chk("sw_W0_data", 128'(W0_data), 128'h3_DEAD_BEEF);
    chk("sw_R0_en_c0", 128'(R0_en), 128'(0));
    @(posedge clock); #1;
    enq_valid = 1'b0;
    #4;
    chk("sw_R0_en_c1", 128'(R0_en), 128'(1));
    chk("sw_R0_addr_c1", 128'(R0_addr), 128'(0));
    chk("sw_count_c1", 128'(count), 128'(1));
    chk("sw_deq_valid_c1", 128'(deq_valid), 128'(0));
    @(posedge clock); #1;
    #4;
    chk("sw_deq_valid_c2", 128'(deq_valid), 128'(0));
    chk("sw_count_c2", 128'(count), 128'(1));
    chk("sw_R0_en_c2", 128'(R0_en), 128'(0));
    @(posedge clock); #1;
    #4;
    chk("sw_deq_valid_c3", 128'(deq_valid), 128'(1));
    chk("sw_deq_bits_c3", 128'(deq_bits), 128'h3_DEAD_BEEF);
    @(posedge clock); #1;
    #4;
    chk("sw_count_c4", 128'(count), 128'(0));
    chk("sw_deq_valid_c4", 128'(deq_valid), 128'(0));
    @(posedge clock); #1;
`endif
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    enq_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 128'(count), 128'(0));
    chk("mid_rst_deq_valid", 128'(deq_valid), 128'(0));
    chk("mid_rst_R0_en", 128'(R0_en), 128'(0));
    chk("mid_rst_W0_en", 128'(W0_en), 128'(0));
    chk("mid_rst_enq_ready", 128'(enq_ready), 128'(0));
    q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    enq_valid = 1'b0;
    #4;
    chk("post_rst_enq_ready", 128'(enq_ready), 128'(1));
    chk("post_rst_count", 128'(count), 128'(0));
    @(posedge clock); #1;
    nxt = '0; n_acc = 0; n_rd = 0;
    for (int i = 0; i < 1000; i++) cyc(1'b1, 1'b0);
    chk("fill_accepted", 128'(n_acc), 128'(DEPTH + 2));
    chk("fill_count", 128'(count), 128'(DEPTH + 2));
    chk("fill_enq_ready", 128'(enq_ready), 128'(0));
    chk("fill_reads", 128'(n_rd), 128'(FILL_RD));
    chk("fill_head", 128'(deq_bits), 128'(0));
    n_deq = 0;
    drain("fill");
    chk("fill_drain_n", 128'(n_deq), 128'(DEPTH + 2));
    n_deq = 0;
    for (int i = 0; i < 2000; i++) cyc(1'b1, 1'b1);
    chk("stream_deq_n", 128'(n_deq), 128'(STREAM_DEQ));
    drain("stream");
    for (int i = 0; i < 10000; i++) cyc($urandom_range(99) < 70, $urandom_range(99) < 30);
    drain("rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
